fsm_loop_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer sharing one 4-state control FSM (Idle/Start/Stop/Clear,

---
 rtl/fsm_loop_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_fsm_loop_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_loop_arbiter.sv
// ----------------------------------------------------------------------------
// fsm_loop_arbiter
//
// Round-robin arbiter and sequencer that shares one external 4-state control
// FSM (Idle/Start/Stop/Clear, single input A) among N requesters. The winner
// of arbitration owns the FSM for one complete loop:
//   Idle -> Start -> Stop -> Clear -> Idle
// Each step is driven through fsm_a and then confirmed by observing fsm_state
// before the next step is driven. When the FSM is back in Idle, the owner
// receives a single-cycle done pulse. This block is the only driver of the
// FSM's A input.
//
// Configuration macro:
//   FSM_LOOP_ARB_WDOG_EN - when defined, a per-phase watchdog aborts a loop
//                          that waits TIMEOUT cycles in one phase (err pulse,
//                          no done). When undefined, err is tied low and
//                          phases wait indefinitely.
//
// Parameters:
//   N        number of requesters (2..8)
//   TIMEOUT  cycles allowed per phase before abort (watchdog build only)
//   CNT_W    watchdog counter width; must be able to hold TIMEOUT
//
// Ports:
//   Clock      in   1  rising-edge clock
//   Reset      in   1  asynchronous, active-low reset
//   req        in   N  level request per client
//   fsm_state  in   2  FSM state: 00 Idle, 01 Start, 10 Stop, 11 Clear
//   fsm_a      out  1  drives FSM input A
//   grant      out  N  one-hot owner of the FSM, held for the whole loop
//   done       out  N  single-cycle pulse to the owner on loop completion
//   busy       out  1  high in every state other than arbitration
//   err        out  1  single-cycle pulse on watchdog abort
// ----------------------------------------------------------------------------
module fsm_loop_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic [N-1:0] req,
    input  logic [1:0]   fsm_state,
    output logic         fsm_a,
    output logic [N-1:0] grant,
    output logic [N-1:0] done,
    output logic         busy,
    output logic         err
);

    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] FsmIdle  = 2'b00;
    localparam logic [1:0] FsmStart = 2'b01;
    localparam logic [1:0] FsmStop  = 2'b10;
    localparam logic [1:0] FsmClear = 2'b11;

    // Elaboration-time parameter sanity checks.
    if (N < 2 || N > 8) begin : g_bad_n
        $error("fsm_loop_arbiter: N must be in 2..8");
    end
    if (CNT_W < 1 || CNT_W > 31 || TIMEOUT < 1 || TIMEOUT >= (32'd1 << CNT_W)) begin : g_bad_cnt
        $error("fsm_loop_arbiter: CNT_W must hold TIMEOUT");
    end

    typedef enum logic [2:0] {
        StArb,
        StHi1,
        StLo1,
        StHi2,
        StLo2,
        StDone
    } state_e;

    state_e           state_q;
    logic [PTR_W-1:0] ptr_q;

    // ------------------------------------------------------------------------
    // Round-robin search: first request at ptr+1 .. ptr+N (mod N), so the
    // most recently served client is always considered last.
    // ------------------------------------------------------------------------
    logic             pick_valid;
    logic [PTR_W-1:0] pick_idx;
    logic [PTR_W-1:0] cand_idx;
    logic [N-1:0]     pick_onehot;
    int unsigned      cand;

    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = ptr_q;
        cand       = 0;
        cand_idx   = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand     = (32'(ptr_q) + i) % N;
            cand_idx = PTR_W'(cand);
            if (!pick_valid && req[cand_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        pick_onehot = {{(N-1){1'b0}}, 1'b1} << pick_idx;
    end

    // ------------------------------------------------------------------------
    // Phase confirmation: each drive phase waits for the FSM state that the
    // value just driven on fsm_a should produce. Any other state is ignored.
    // ------------------------------------------------------------------------
    logic   phase_hit;
    state_e phase_next;

    always_comb begin
        phase_hit  = 1'b0;
        phase_next = StArb;
        case (state_q)
            StHi1: begin
                phase_hit  = (fsm_state == FsmStart);
                phase_next = StLo1;
            end
            StLo1: begin
                phase_hit  = (fsm_state == FsmStop);
                phase_next = StHi2;
            end
            StHi2: begin
                phase_hit  = (fsm_state == FsmClear);
                phase_next = StLo2;
            end
            StLo2: begin
                phase_hit  = (fsm_state == FsmIdle);
                phase_next = StDone;
            end
            default: begin
                phase_hit  = 1'b0;
                phase_next = StArb;
            end
        endcase
    end

`ifdef FSM_LOOP_ARB_WDOG_EN
    logic [CNT_W-1:0] cnt_q;
    logic             wdog_fire;

    // The counter reaches TIMEOUT on the edge that fires, so the abort lands
    // exactly TIMEOUT cycles after phase entry.
    always_comb begin
        wdog_fire = (cnt_q == CNT_W'(TIMEOUT - 1));
    end
`else
    assign err = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs.
    // ------------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= StArb;
            ptr_q   <= PTR_W'(N - 1);
            fsm_a   <= 1'b0;
            grant   <= '0;
            done    <= '0;
            busy    <= 1'b0;
`ifdef FSM_LOOP_ARB_WDOG_EN
            err     <= 1'b0;
            cnt_q   <= '0;
`endif
        end else begin
            done <= '0;
`ifdef FSM_LOOP_ARB_WDOG_EN
            err  <= 1'b0;
`endif
            case (state_q)
                StArb: begin
                    fsm_a <= 1'b0;
                    // Only start a loop from a quiescent FSM.
                    if (pick_valid && (fsm_state == FsmIdle)) begin
                        grant   <= pick_onehot;
                        busy    <= 1'b1;
                        ptr_q   <= pick_idx;
                        fsm_a   <= 1'b1;
                        state_q <= StHi1;
`ifdef FSM_LOOP_ARB_WDOG_EN
                        cnt_q   <= '0;
`endif
                    end
                end

                StHi1, StLo1, StHi2, StLo2: begin
                    if (phase_hit) begin
                        state_q <= phase_next;
                        // Only the Stop->Clear step needs A high again.
                        fsm_a   <= (phase_next == StHi2);
                        if (phase_next == StDone) begin
                            done  <= grant;
                            grant <= '0;
                        end
`ifdef FSM_LOOP_ARB_WDOG_EN
                        cnt_q   <= '0;
                    end else if (wdog_fire) begin
                        // Abort: release the FSM without a done pulse. The
                        // pointer already names the aborted client, so it is
                        // searched last next time.
                        err     <= 1'b1;
                        fsm_a   <= 1'b0;
                        grant   <= '0;
                        busy    <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= StArb;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
`endif
                    end
                end

                StDone: begin
                    busy    <= 1'b0;
                    state_q <= StArb;
                end

                default: begin
                    fsm_a   <= 1'b0;
                    grant   <= '0;
                    busy    <= 1'b0;
                    state_q <= StArb;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_loop_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fsm_loop_arbiter
//
// Directed bench for fsm_loop_arbiter (N=4, TIMEOUT=16). A behavioural model
// of the shared control FSM responds to fsm_a one cycle later; it can be held
// in Start to exercise the stuck-phase path.
// ----------------------------------------------------------------------------
module tb_fsm_loop_arbiter;

    localparam int unsigned N = 4;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic [1:0]   fsm_state;
    logic         fsm_a;
    logic [N-1:0] grant;
    logic [N-1:0] done;
    logic         busy;
    logic         err;
    logic         stuck;

    int checks   = 0;
    int failures = 0;

    fsm_loop_arbiter #(
        .N       (N),
        .TIMEOUT (16),
        .CNT_W   (5)
    ) dut (
        .Clock     (clk),
        .Reset     (rst_n),
        .req       (req),
        .fsm_state (fsm_state),
        .fsm_a     (fsm_a),
        .grant     (grant),
        .done      (done),
        .busy      (busy),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Shared FSM: Idle -A-> Start -!A-> Stop -A-> Clear -!A-> Idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_state <= 2'b00;
        end else begin
            case (fsm_state)
                2'b00: if (fsm_a) fsm_state <= 2'b01;
                2'b01: if (!fsm_a && !stuck) fsm_state <= 2'b10;
                2'b10: if (fsm_a) fsm_state <= 2'b11;
                default: if (!fsm_a) fsm_state <= 2'b00;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        req   = '0;
        stuck = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({fsm_a, grant, done, busy, err} !== 11'b0) begin
            failures++;
            $display("FAIL reset_async: outputs=%b required=0", {fsm_a, grant, done, busy, err});
        end
        step();
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            checks++;
            if ({fsm_a, grant, done, busy, err} !== 11'b0) begin
                failures++;
                $display("FAIL reset_idle cyc%0d: outputs=%b required=0",
                         c, {fsm_a, grant, done, busy, err});
            end
        end
    endtask

    // Single loop for client 0 with a 1-cycle FSM. Cycle 0 is the grant edge;
    // done arrives on the 9th loop cycle (index 8) as grant drops.
    task automatic test_single_loop();
        logic exp_a [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        do_reset();
        req = 4'b0001;
        step();
        req = 4'b0000;
        for (int c = 0; c < 9; c++) begin
            if (c > 0) step();
            checks++;
            if (fsm_a !== exp_a[c]) begin
                failures++;
                $display("FAIL single_fsm_a cyc%0d: got %b required %b", c, fsm_a, exp_a[c]);
            end
            checks++;
            if (grant !== ((c < 8) ? 4'b0001 : 4'b0000)) begin
                failures++;
                $display("FAIL single_grant cyc%0d: got %b required %b", c, grant,
                         (c < 8) ? 4'b0001 : 4'b0000);
            end
            checks++;
            if (done !== ((c == 8) ? 4'b0001 : 4'b0000)) begin
                failures++;
                $display("FAIL single_done cyc%0d: got %b required %b", c, done,
                         (c == 8) ? 4'b0001 : 4'b0000);
            end
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL single_busy cyc%0d: got %b required 1", c, busy);
            end
        end
        step();
        checks++;
        if (busy !== 1'b0 || done !== 4'b0000) begin
            failures++;
            $display("FAIL single_after: busy=%b done=%b required 0/0000", busy, done);
        end
    endtask

    // req=1011 held from reset: 0001, 0010, 1000, 0001.
    task automatic test_round_robin();
        logic [N-1:0] exp_g [4] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
        logic [N-1:0] prev_g;
        int           n;
        do_reset();
        req    = 4'b1011;
        prev_g = '0;
        n      = 0;
        for (int c = 0; c < 80 && n < 4; c++) begin
            step();
            if (done !== 4'b0000) begin
                checks++;
                if (done !== prev_g) begin
                    failures++;
                    $display("FAIL rr_done: got %b required %b", done, prev_g);
                end
            end
            if (grant !== 4'b0000 && prev_g === 4'b0000) begin
                checks++;
                if (grant !== exp_g[n]) begin
                    failures++;
                    $display("FAIL rr_grant%0d: got %b required %b", n, grant, exp_g[n]);
                end
                n++;
            end
            prev_g = grant;
        end
        checks++;
        if (n != 4) begin
            failures++;
            $display("FAIL rr_timeout: grants seen %0d required 4", n);
        end
        req = '0;
        for (int c = 0; c < 12; c++) step();
    endtask

    // Client 0 drops its request in LO1; loop still completes, then client 2.
    task automatic test_owner_drop();
        do_reset();
        req = 4'b0101;
        step();
        checks++;
        if (grant !== 4'b0001) begin
            failures++;
            $display("FAIL drop_grant0: got %b required 0001", grant);
        end
        step();
        step();
        checks++;
        if (fsm_a !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL drop_lo1: fsm_a=%b busy=%b required 0/1", fsm_a, busy);
        end
        req = 4'b0100;
        for (int c = 0; c < 6; c++) step();
        checks++;
        if (done !== 4'b0001 || grant !== 4'b0000) begin
            failures++;
            $display("FAIL drop_done: done=%b grant=%b required 0001/0000", done, grant);
        end
        step();
        step();
        checks++;
        if (grant !== 4'b0100) begin
            failures++;
            $display("FAIL drop_next: got %b required 0100", grant);
        end
        req = '0;
    endtask

    // FSM held in Start: LO1 is entered 2 cycles after grant and never confirmed.
    task automatic test_stuck_phase();
        logic saw_done;
        do_reset();
        stuck = 1'b1;
        req   = 4'b0001;
        step();
        req      = 4'b0000;
        saw_done = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (done !== 4'b0000) saw_done = 1'b1;
            if (c == 2) begin
                checks++;
                if (fsm_a !== 1'b0) begin
                    failures++;
                    $display("FAIL stuck_lo1: fsm_a=%b required 0", fsm_a);
                end
            end
`ifdef FSM_LOOP_ARB_WDOG_EN
            if (c == 17) begin
                checks++;
                if (err !== 1'b0 || grant !== 4'b0001) begin
                    failures++;
                    $display("FAIL wdog_early: err=%b grant=%b required 0/0001", err, grant);
                end
            end
            if (c == 18) begin
                checks++;
                if (err !== 1'b1 || grant !== 4'b0000 || fsm_a !== 1'b0 || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL wdog_abort: err=%b grant=%b fsm_a=%b busy=%b required 1/0000/0/0",
                             err, grant, fsm_a, busy);
                end
            end
            if (c == 19) begin
                checks++;
                if (err !== 1'b0) begin
                    failures++;
                    $display("FAIL wdog_pulse: err=%b required 0", err);
                end
            end
`else
            if (c == 18 || c == 20) begin
                checks++;
                if (busy !== 1'b1 || grant !== 4'b0001 || err !== 1'b0) begin
                    failures++;
                    $display("FAIL stuck_wait cyc%0d: busy=%b grant=%b err=%b required 1/0001/0",
                             c, busy, grant, err);
                end
            end
`endif
        end
        checks++;
        if (saw_done !== 1'b0) begin
            failures++;
            $display("FAIL stuck_no_done: done pulse seen=%b required 0", saw_done);
        end
        stuck = 1'b0;
    endtask

    // Reset in HI2 drops outputs asynchronously; pointer restarts at N-1.
    task automatic test_reset_mid_loop();
        do_reset();
        req = 4'b0001;
        step();
        req = 4'b0000;
        for (int c = 0; c < 4; c++) step();
        checks++;
        if (fsm_a !== 1'b1 || busy !== 1'b1 || grant !== 4'b0001) begin
            failures++;
            $display("FAIL mid_hi2: fsm_a=%b busy=%b grant=%b required 1/1/0001",
                     fsm_a, busy, grant);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (fsm_a !== 1'b0 || busy !== 1'b0 || grant !== 4'b0000 || done !== 4'b0000) begin
            failures++;
            $display("FAIL mid_reset: fsm_a=%b busy=%b grant=%b done=%b required 0/0/0000/0000",
                     fsm_a, busy, grant, done);
        end
        step();
        step();
        rst_n = 1'b1;
        req   = 4'b0010;
        step();
        checks++;
        if (grant !== 4'b0010) begin
            failures++;
            $display("FAIL mid_regrant: got %b required 0010", grant);
        end
        req = '0;
        for (int c = 0; c < 12; c++) step();
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        stuck = 1'b0;
        test_reset();
        test_single_loop();
        test_round_robin();
        test_owner_drop();
        test_stuck_phase();
        test_reset_mid_loop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1);
    end

endmodule
